sprite_rom_arbiter: RTL

//  Shares one single-port sprite/palette ROM among NUM_REQ pixel-path requesters (e.g. Mario, enemy, tile fetch)

---
 rtl/sprite_rom_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin sprite ROM arbiter with locked bursts and tagged read return
module sprite_rom_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_rd,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic                      busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   owner;
    logic [BCW-1:0]   beat_cnt;
    logic             tag_v  [RD_LAT];
    logic [IDW-1:0]   tag_id [RD_LAT];

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   sel_id;
    logic             xfer;
    logic             is_last;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    // Search starts at rr_ptr so the most recent winner has lowest priority next time.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_id   = (state == BURST) ? owner : win_id;
        xfer     = !Reset && ((state == BURST) ? req[owner] : win_found);
        is_last  = req_last[sel_id];
        gnt      = xfer ? (NUM_REQ'(1) << sel_id) : '0;
        rom_rd   = xfer;
        rom_addr = xfer ? req_addr[int'(sel_id)*ADDR_W +: ADDR_W] : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (is_last || MAX_BURST == 1) begin
                            rr_ptr <= next_id(win_id);
                        end else begin
                            state    <= BURST;
                            owner    <= win_id;
                            beat_cnt <= BCW'(1);
                        end
                    end
                end
                BURST: begin
                    // An idle owner keeps the lock; only last or the beat cap releases it.
                    if (xfer) begin
                        if (is_last || (beat_cnt + 1'b1) == BCW'(MAX_BURST)) begin
                            state    <= IDLE;
                            rr_ptr   <= next_id(owner);
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= xfer;
            tag_id[0] <= sel_id;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign rvalid = tag_v[RD_LAT-1] ? (NUM_REQ'(1) << tag_id[RD_LAT-1]) : '0;
    assign rdata  = rom_data;
    assign busy   = (state == BURST);

endmodule
